// File: rtl/prog_mem_arbiter.sv
// Shares the program memory read port between the fetch unit (port 0) and a
// secondary reader (port 1), steering each response back to its owner.
module prog_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int MEM_LATENCY  = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        mem_ready_in,
  input  logic        req0_in,
  input  logic        req1_in,
  input  logic [31:0] addr0_in,
  input  logic [31:0] addr1_in,
  output logic        grant0_out,
  output logic        grant1_out,
  output logic        valid0_out,
  output logic        valid1_out,
  output logic [31:0] instr_out,
  output logic [31:0] mem_addr_out,
  output logic        mem_read_request_out,
  input  logic [31:0] mem_instr_in,
  input  logic        mem_data_valid_in,
  output logic        busy_out
);

  localparam int         DEPTH = MEM_LATENCY + 1;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]       starve_cnt;
  logic             starved;
  logic             grant_any;
  logic [DEPTH-1:0] tag_valid;
  logic [DEPTH-1:0] tag_owner;

  // Handshake: a requester holds req/addr until it sees its grant high in a
  // cycle; that cycle is the transfer, and it may change or drop req next cycle.
  always_comb begin
    grant0_out = 1'b0;
    grant1_out = 1'b0;
    starved    = (starve_cnt == LIMIT);
    if (mem_ready_in && !rst_in) begin
      if (starved && req1_in)
        grant1_out = 1'b1;
      else if (req0_in)
        grant0_out = 1'b1;
      else if (req1_in)
        grant1_out = 1'b1;
    end
  end

  assign grant_any = grant0_out | grant1_out;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      starve_cnt           <= 4'd0;
      mem_read_request_out <= 1'b0;
      mem_addr_out         <= 32'd0;
      tag_valid            <= '0;
      tag_owner            <= '0;
    end else begin
      // While memory is still loading nobody is refused, so the count holds.
      if (mem_ready_in) begin
        if (grant1_out || !req1_in)
          starve_cnt <= 4'd0;
        else if (starve_cnt < LIMIT)
          starve_cnt <= starve_cnt + 4'd1;
      end
      mem_read_request_out <= grant_any;
      if (grant0_out)
        mem_addr_out <= addr0_in;
      else if (grant1_out)
        mem_addr_out <= addr1_in;
      tag_valid <= {tag_valid[DEPTH-2:0], grant_any};
      tag_owner <= {tag_owner[DEPTH-2:0], grant1_out};
    end
  end

  // The oldest tag lines up with the memory's data_valid for that read.
  assign valid0_out = mem_data_valid_in & tag_valid[DEPTH-1] & ~tag_owner[DEPTH-1];
  assign valid1_out = mem_data_valid_in & tag_valid[DEPTH-1] &  tag_owner[DEPTH-1];
  assign instr_out  = mem_instr_in;
  assign busy_out   = |tag_valid;

endmodule
